// File: rtl/tx_counter_pkg.sv
// Shared types and defaults for the USB TX cascade counter.
package tx_counter_pkg;

   typedef enum logic {
      MODE_WRAP    = 1'b0,
      MODE_ONESHOT = 1'b1
   } cnt_mode_t;

   localparam int TX_PRE_WIDTH_DEF = 4;
   localparam int TX_CNT_WIDTH_DEF = 4;

endpackage

// File: rtl/tx_counter_stage.sv
// One flex-counter stage: wraps to 1 after reaching a nonzero terminal value,
// free-runs modulo 2^WIDTH when the terminal value is 0.
module tx_counter_stage
   import tx_counter_pkg::*;
#(
   parameter int WIDTH = TX_CNT_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] rollover_val,
   output logic [WIDTH-1:0] count_out,
   output logic             rollover_flag,
   output logic             at_terminal
);

   logic [WIDTH-1:0] count_r;
   logic [WIDTH-1:0] count_nxt_s;
   logic [WIDTH-1:0] count_inc_s;
   logic             flag_r;
   logic             flag_nxt_s;
   logic             r_nz_s;

   assign r_nz_s      = (rollover_val != {WIDTH{1'b0}});
   assign count_inc_s = count_r + WIDTH'(1);

   // Next count/flag from clear, enable and terminal comparison
   always_comb begin
      count_nxt_s = count_r;
      flag_nxt_s  = flag_r;
      if (clear) begin
         count_nxt_s = {WIDTH{1'b0}};
         flag_nxt_s  = 1'b0;
      end else if (enable) begin
         if (r_nz_s && (count_r == rollover_val)) begin
            count_nxt_s = WIDTH'(1);
            flag_nxt_s  = 1'b0;
         end else begin
            count_nxt_s = count_inc_s;
            flag_nxt_s  = r_nz_s && (count_inc_s == rollover_val);
         end
      end else begin
         count_nxt_s = count_r;
         flag_nxt_s  = flag_r;
      end
   end

   // Count and flag registers
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_r <= {WIDTH{1'b0}};
         flag_r  <= 1'b0;
      end else begin
         count_r <= count_nxt_s;
         flag_r  <= flag_nxt_s;
      end
   end

   assign count_out     = count_r;
   assign rollover_flag = flag_r;
   assign at_terminal   = r_nz_s && (count_r == rollover_val);

endmodule

// File: rtl/tx_cascade_counter.sv
// Prescaler + main flex counter with wrap/one-shot mode and sticky done.
// Optional registered strobe output under TX_CASCADE_COUNTER_STROBE_EN.
module tx_cascade_counter
   import tx_counter_pkg::*;
#(
   parameter int PRE_WIDTH = TX_PRE_WIDTH_DEF,
   parameter int CNT_WIDTH = TX_CNT_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 clear,
   input  logic                 count_enable,
   input  cnt_mode_t            mode,
   input  logic [PRE_WIDTH-1:0] pre_rollover_val,
   input  logic [CNT_WIDTH-1:0] rollover_val,
   output logic [PRE_WIDTH-1:0] pre_count_out,
   output logic [CNT_WIDTH-1:0] count_out,
   output logic                 pre_rollover_flag,
   output logic                 rollover_flag,
   output logic                 done
`ifdef TX_CASCADE_COUNTER_STROBE_EN
   ,
   output logic                 strobe
`endif
);

   logic pre_en_s;
   logic main_adv_s;
   logic terminal_s;
   logic pre_step_s;
   logic main_step_s;
   logic pre_at_term_s;
   logic main_at_term_s;
   logic done_r;
   logic done_nxt_s;

   assign pre_en_s    = count_enable & ~done_r;
   assign main_adv_s  = pre_en_s & pre_at_term_s;
   assign terminal_s  = main_adv_s & main_at_term_s & (mode == MODE_ONESHOT);
   // A terminal event freezes both stages; only done moves.
   assign pre_step_s  = pre_en_s & ~terminal_s;
   assign main_step_s = main_adv_s & ~terminal_s;

   tx_counter_stage #(.WIDTH(PRE_WIDTH)) u_pre (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (clear),
      .enable        (pre_step_s),
      .rollover_val  (pre_rollover_val),
      .count_out     (pre_count_out),
      .rollover_flag (pre_rollover_flag),
      .at_terminal   (pre_at_term_s)
   );

   tx_counter_stage #(.WIDTH(CNT_WIDTH)) u_main (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (clear),
      .enable        (main_step_s),
      .rollover_val  (rollover_val),
      .count_out     (count_out),
      .rollover_flag (rollover_flag),
      .at_terminal   (main_at_term_s)
   );

   // Sticky done: set on terminal event, released only by clear
   always_comb begin
      done_nxt_s = done_r;
      if (clear) begin
         done_nxt_s = 1'b0;
      end else if (terminal_s) begin
         done_nxt_s = 1'b1;
      end else begin
         done_nxt_s = done_r;
      end
   end

   // Done register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         done_r <= 1'b0;
      end else begin
         done_r <= done_nxt_s;
      end
   end

   assign done = done_r;

`ifdef TX_CASCADE_COUNTER_STROBE_EN
   logic strobe_r;
   logic strobe_nxt_s;

   // Strobe follows each main-stage advance by one cycle
   always_comb begin
      strobe_nxt_s = 1'b0;
      if (clear) begin
         strobe_nxt_s = 1'b0;
      end else begin
         strobe_nxt_s = main_step_s;
      end
   end

   // Strobe register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         strobe_r <= 1'b0;
      end else begin
         strobe_r <= strobe_nxt_s;
      end
   end

   assign strobe = strobe_r;
`endif

endmodule

// File: tb/tb_tx_cascade_counter.sv
// Directed bench for tx_cascade_counter with a cycle-level reference model.
module tb_tx_cascade_counter;
   import tx_counter_pkg::*;

   logic       clk;
   logic       n_rst;
   logic       clear;
   logic       count_enable;
   cnt_mode_t  mode;
   logic [3:0] pre_rollover_val;
   logic [3:0] rollover_val;
   logic [3:0] pre_count_out;
   logic [3:0] count_out;
   logic       pre_rollover_flag;
   logic       rollover_flag;
   logic       done;
`ifdef TX_CASCADE_COUNTER_STROBE_EN
   logic       strobe;
`endif

   int vec_cnt = 0;
   int err_cnt = 0;

   tx_cascade_counter #(.PRE_WIDTH(4), .CNT_WIDTH(4)) dut (
      .clk               (clk),
      .n_rst             (n_rst),
      .clear             (clear),
      .count_enable      (count_enable),
      .mode              (mode),
      .pre_rollover_val  (pre_rollover_val),
      .rollover_val      (rollover_val),
      .pre_count_out     (pre_count_out),
      .count_out         (count_out),
      .pre_rollover_flag (pre_rollover_flag),
      .rollover_flag     (rollover_flag),
      .done              (done)
`ifdef TX_CASCADE_COUNTER_STROBE_EN
      ,
      .strobe            (strobe)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int pre;
      int cnt;
      bit pf;
      bit cf;
      bit dn;
      bit str;
   } mstate_t;

   mstate_t m;

   // Flex-counter rule on plain integers, counts modulo 16
   function automatic void stage_next(input int c, input int r, output int nc, output bit nf);
      if (r != 0 && c == r) begin
         nc = 1;
         nf = 1'b0;
      end else begin
         nc = (c + 1) % 16;
         nf = (r != 0) && (nc == r);
      end
   endfunction

   function automatic mstate_t model_next(input mstate_t s, input bit clr, input bit en,
                                          input bit oneshot, input int p, input int r);
      mstate_t n;
      bit adv_pre, adv_main, term;
      n = s;
      n.str = 1'b0;
      if (clr) begin
         n = '{pre: 0, cnt: 0, pf: 1'b0, cf: 1'b0, dn: 1'b0, str: 1'b0};
      end else begin
         adv_pre  = en && !s.dn;
         adv_main = adv_pre && p != 0 && s.pre == p;
         term     = adv_main && r != 0 && s.cnt == r && oneshot;
         if (term) begin
            n.dn = 1'b1;
         end else begin
            if (adv_pre) stage_next(s.pre, p, n.pre, n.pf);
            if (adv_main) begin
               stage_next(s.cnt, r, n.cnt, n.cf);
               n.str = 1'b1;
            end
         end
      end
      return n;
   endfunction

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         m <= '{pre: 0, cnt: 0, pf: 1'b0, cf: 1'b0, dn: 1'b0, str: 1'b0};
      else
         m <= model_next(m, clear, count_enable, mode == MODE_ONESHOT,
                         int'(pre_rollover_val), int'(rollover_val));
   end

   task automatic check(input string name, input int act, input int exp);
      vec_cnt++;
      if (act != exp) begin
         err_cnt++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Compare DUT against the model every falling edge
   always @(negedge clk) begin
      check("pre_count_out", int'(pre_count_out), m.pre);
      check("count_out", int'(count_out), m.cnt);
      check("pre_rollover_flag", int'(pre_rollover_flag), int'(m.pf));
      check("rollover_flag", int'(rollover_flag), int'(m.cf));
      check("done", int'(done), int'(m.dn));
`ifdef TX_CASCADE_COUNTER_STROBE_EN
      check("strobe", int'(strobe), int'(m.str));
`endif
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_pre"}, int'(pre_count_out), 0);
      check({tag, "_cnt"}, int'(count_out), 0);
      check({tag, "_pflag"}, int'(pre_rollover_flag), 0);
      check({tag, "_flag"}, int'(rollover_flag), 0);
      check({tag, "_done"}, int'(done), 0);
`ifdef TX_CASCADE_COUNTER_STROBE_EN
      check({tag, "_strobe"}, int'(strobe), 0);
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_rst = 1'b1;
      clear = 1'b0;
      count_enable = 1'b0;
      mode = MODE_WRAP;
      pre_rollover_val = 4'd0;
      rollover_val = 4'd0;
      #1 n_rst = 1'b0;
      #1 check_all_zero("reset");
      @(posedge clk);
      #1 n_rst = 1'b1;

      // Wrap mode, pre=3 main=2
      pre_rollover_val = 4'd3;
      rollover_val = 4'd2;
      count_enable = 1'b1;
      cyc(3);
      check("t1_pre_c3", int'(pre_count_out), 3);
      check("t1_cnt_c3", int'(count_out), 0);
      cyc(1);
      check("t1_pre_c4", int'(pre_count_out), 1);
      check("t1_cnt_c4", int'(count_out), 1);
      cyc(3);
      check("t1_cnt_c7", int'(count_out), 2);
      check("t1_flag_c7", int'(rollover_flag), 1);
      cyc(3);
      check("t1_cnt_c10", int'(count_out), 1);
      check("t1_flag_c10", int'(rollover_flag), 0);

      // One-shot, pre=2 main=3
      clear = 1'b1;
      count_enable = 1'b0;
      cyc(1);
      clear = 1'b0;
      check_all_zero("t2_clr");
      mode = MODE_ONESHOT;
      pre_rollover_val = 4'd2;
      rollover_val = 4'd3;
      count_enable = 1'b1;
      cyc(8);
      check("t2_cnt_c8", int'(count_out), 3);
      check("t2_done_c8", int'(done), 0);
      cyc(1);
      check("t2_done_c9", int'(done), 1);
      check("t2_pre_c9", int'(pre_count_out), 2);
      check("t2_cnt_c9", int'(count_out), 3);
      cyc(20);
      check("t2_done_hold", int'(done), 1);
      check("t2_pre_hold", int'(pre_count_out), 2);
      check("t2_cnt_hold", int'(count_out), 3);
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      check_all_zero("t2_release");

      // Enable every other cycle, pre=4
      mode = MODE_WRAP;
      pre_rollover_val = 4'd4;
      rollover_val = 4'd5;
      repeat (4) begin
         count_enable = 1'b1;
         cyc(1);
         count_enable = 1'b0;
         cyc(1);
      end
      check("t3_pre_e4", int'(pre_count_out), 4);
      check("t3_cnt_e4", int'(count_out), 0);
      count_enable = 1'b1;
      cyc(1);
      count_enable = 1'b0;
      check("t3_pre_e5", int'(pre_count_out), 1);
      check("t3_cnt_e5", int'(count_out), 1);
      cyc(1);
      check("t3_pre_idle", int'(pre_count_out), 1);

      // Clear together with enable at pre=3 count=1
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      pre_rollover_val = 4'd3;
      rollover_val = 4'd2;
      count_enable = 1'b1;
      cyc(6);
      check("t4_pre_pre", int'(pre_count_out), 3);
      check("t4_cnt_pre", int'(count_out), 1);
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      check_all_zero("t4_clr_en");

      // Prescaler terminal value of zero free-runs
      pre_rollover_val = 4'd0;
      cyc(15);
      check("t5_pre_15", int'(pre_count_out), 15);
      cyc(1);
      check("t5_pre_wrap", int'(pre_count_out), 0);
      check("t5_cnt", int'(count_out), 0);
      check("t5_pflag", int'(pre_rollover_flag), 0);

      // Strobe spacing and asynchronous reset mid-count
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      pre_rollover_val = 4'd2;
      rollover_val = 4'd3;
      cyc(3);
      check("t6_cnt_c3", int'(count_out), 1);
`ifdef TX_CASCADE_COUNTER_STROBE_EN
      check("t6_strobe_c3", int'(strobe), 1);
      cyc(1);
      check("t6_strobe_c4", int'(strobe), 0);
      cyc(1);
      check("t6_strobe_c5", int'(strobe), 1);
`else
      cyc(2);
`endif
      check("t6_cnt_c5", int'(count_out), 2);
      #2 n_rst = 1'b0;
      #1 check_all_zero("t6_async_rst");
      n_rst = 1'b1;
      cyc(3);
      check("t6_pre_after", int'(pre_count_out), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/tx_cascade_counter.md
# tx_cascade_counter

Two-stage parametrised flex counter: a prescaler stage whose wrap advances a main stage, with wrap or one-shot mode and a sticky done flag. Each stage keeps the flex-counter semantics the USB TX path already relies on. Used in the USB TX path to derive bit timing (clocks per bit) and bit/byte counts (bits per packet field) from one block.

## Interface
- PRE_WIDTH, 4, prescaler stage width
- CNT_WIDTH, 4, main stage width
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- clear  input  1  synchronous clear of both stages and done; highest priority
- count_enable  input  1  advance prescaler this cycle
- mode  input  1  cnt_mode_t: MODE_WRAP (0) or MODE_ONESHOT (1)
- pre_rollover_val  input  PRE_WIDTH  prescaler terminal value
- rollover_val  input  CNT_WIDTH  main terminal value
- pre_count_out  output  PRE_WIDTH  prescaler count
- count_out  output  CNT_WIDTH  main count
- pre_rollover_flag  output  1  high while pre_count_out == pre_rollover_val (nonzero)
- rollover_flag  output  1  high while count_out == rollover_val (nonzero)
- done  output  1  sticky one-shot completion
- strobe  output  1  present only with TX_CASCADE_COUNTER_STROBE_EN

## Operation
- Stage rule, for a stage with enable e and terminal value R:
  - clear sets count to 0 and flag to 0.
  - Otherwise, if e is high and count == R, the count goes to 1 (not 0) and the flag goes to 0.
  - If e is high and count+1 == R, the count increments and the flag goes to 1.
  - If e is high otherwise, the count increments and the flag goes to 0.
  - If e is low, count and flag hold.
- R == 0: the stage increments modulo 2^W and its flag stays 0.
- Prescaler enable: count_enable && !done.
- Main enable: count_enable && !done && pre_count_out == pre_rollover_val && pre_rollover_val != 0. The main stage advances in the same cycle the prescaler wraps to 1.
- Terminal event: main enable is high while count_out == rollover_val, rollover_val != 0, and mode == MODE_ONESHOT.
  - On a terminal event, neither stage changes. done is set at the next edge.
  - While done is set, all counts and flags hold regardless of count_enable.
  - Only clear or reset releases done.
- MODE_WRAP: done never sets. The main stage wraps to 1 exactly as the prescaler does.
- mode may change at any time; it is sampled every cycle.
- Changing rollover values mid-count takes effect on the next comparison, with no reset of counts. If a count already exceeds the new R, it runs up to 2^W-1, wraps to 0, and continues.

## Timing
- Reset values: pre_count_out=0, count_out=0, both flags 0, done=0, strobe=0.
- All outputs are registered, and nothing on the outputs has a combinational path from inputs.
- Latency: one cycle from an enabled edge to the updated count and flag.
- After clear with P=pre_rollover_val:
  - The first main increment happens on the (P+1)th enabled cycle.
  - Each later main increment happens every P enabled cycles.
- Simultaneous clear and count_enable: clear wins; counts become 0.
- A clear asserted while done is set drops done at the next edge.
- Reset mid-count returns all outputs to reset values asynchronously.

## Configuration
- TX_CASCADE_COUNTER_STROBE_EN defined:
  - The strobe output exists.
  - strobe is a registered one-cycle pulse, high in exactly the cycles where count_out took a new value from a main-stage advance.
  - strobe is 0 after clear, after reset, and while done is set.
- Undefined: the strobe port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package tx_counter_pkg holds:
  - cnt_mode_t enum (MODE_WRAP, MODE_ONESHOT)
  - defaults TX_PRE_WIDTH_DEF=4 and TX_CNT_WIDTH_DEF=4
- Sub-module tx_counter_stage (parameter WIDTH; ports clk, n_rst, clear, enable, rollover_val, count_out, rollover_flag, plus combinational at_terminal). It is instantiated twice, once for the prescaler and once for the main stage.
- The top level holds the enable gating, the done register, and the optional strobe register.

## Test plan
- Reset then release; hold count_enable=1 with pre=3, main=2, MODE_WRAP.
  - Required sequence: pre 1,2,3,1,2,3,1…
  - count_out goes to 1 on cycle 4, 2 on cycle 7, 1 on cycle 10.
  - rollover_flag is high only while count_out==2.
- MODE_ONESHOT, pre=2, main=3, continuous enable.
  - Counts freeze at pre=2, count=3.
  - done rises the cycle after the terminal event and stays high for 20 more cycles.
  - Assert clear: all outputs go to 0 next edge.
- Toggle count_enable every other cycle with pre=4.
  - Counts advance only on enabled cycles.
  - The first main increment occurs on the 5th enabled cycle.
- Assert clear together with count_enable at pre=3, count=1: next edge all outputs are 0.
- pre_rollover_val=0: pre counts 0..15 and wraps to 0; count_out stays 0 and both flags stay 0.
- With TX_CASCADE_COUNTER_STROBE_EN, pre=2, main=3:
  - strobe pulses one cycle per main advance (cycles 3, 5, 7, …).
  - Pulse it mid-count with n_rst low: all outputs are 0 immediately.
